// File: rtl/instr_encoder.sv
// Instruction encoder: packs request fields into 32-bit words and hands them to
// instruction memory with an address. Define INSTR_ENCODER_CHECK_EN to reject illegal requests.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rn,
  input  logic [3:0]  Rd,
  input  logic [11:0] Src2,
  input  logic [23:0] Imm24,
  input  logic        Last,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Instr,
  output logic [31:0] Addr,
  output logic        Err,
  output logic        Done,
  input  logic        Clear,
  output logic [15:0] Count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0]  OP_BRANCH = 2'b10;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] next_addr_q, next_addr_d;
  logic        last_q, last_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  logic        ready_raw;
  logic        accept;
  logic        mem_hs;
  logic        illegal;
  logic        load_word;
  logic [31:0] enc_word;

`ifdef INSTR_ENCODER_CHECK_EN
  // Multiply with an out-of-range function, or a data-processing compare form
  // that is missing its mandatory flag-setting bit.
  function automatic logic is_illegal(input logic [1:0] op, input logic [5:0] funct);
    logic mul_bad;
    logic dp_bad;
    mul_bad = (op == 2'b11) && (funct[4:1] > 4'b1000);
    dp_bad  = (op == 2'b00) && ((funct[4:1] == 4'b1010) || (funct[4:1] == 4'b1011))
              && !funct[0];
    return mul_bad || dp_bad;
  endfunction

  assign illegal = is_illegal(Op, Funct);
`else
  assign illegal = 1'b0;
`endif

  // Branches replace the low function bits and register fields with the offset.
  always_comb begin
    if (Op == OP_BRANCH) enc_word = {Cond, Op, Funct[5:4], Imm24};
    else                 enc_word = {Cond, Op, Funct, Rn, Rd, Src2};
  end

  // A word carrying Last blocks new requests during its own handshake.
  always_comb begin
    ready_raw = 1'b0;
    unique case (state_q)
      IDLE:    ready_raw = 1'b1;
      OUT:     ready_raw = Out_Ready & ~last_q;
      default: ready_raw = 1'b0;
    endcase
  end

  assign In_Ready  = ready_raw & ~reset;
  assign accept    = In_Valid & In_Ready;
  assign mem_hs    = (state_q == OUT) & Out_Ready;
  assign load_word = accept & ~illegal;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    state_d     = state_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    last_d      = last_q;
    count_d     = count_q;
    err_d       = accept & illegal;

    if (mem_hs && (count_q != COUNT_MAX)) count_d = count_q + 16'd1;

    if (load_word) begin
      instr_d     = enc_word;
      addr_d      = next_addr_q;
      next_addr_d = next_addr_q + ADDR_STEP;
      last_d      = Last;
    end

    unique case (state_q)
      IDLE: begin
        if (load_word)            state_d = OUT;
        else if (accept && Last)  state_d = DONE;
      end
      OUT: begin
        if (Out_Ready) begin
          if (last_q)               state_d = DONE;
          else if (load_word)       state_d = OUT;
          else if (accept && Last)  state_d = DONE;
          else                      state_d = IDLE;
        end
      end
      DONE: begin
        if (Clear) begin
          state_d     = IDLE;
          addr_d      = BASE_ADDR;
          next_addr_d = BASE_ADDR;
          count_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      addr_q      <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      last_q      <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      last_q      <= last_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign Out_Valid = (state_q == OUT);
  assign Done      = (state_q == DONE);
  assign Instr     = instr_q;
  assign Addr      = addr_q;
  assign Count     = count_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam longint      STEP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  cond = '0;
  logic [1:0]  op = '0;
  logic [5:0]  funct = '0;
  logic [3:0]  rn = '0;
  logic [3:0]  rd = '0;
  logic [11:0] src2 = '0;
  logic [23:0] imm24 = '0;
  logic        last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        err;
  logic        done;
  logic        clear = 1'b0;
  logic [15:0] count;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on = 1'b0;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .In_Valid(in_valid), .In_Ready(in_ready),
    .Cond(cond), .Op(op), .Funct(funct), .Rn(rn), .Rd(rd), .Src2(src2),
    .Imm24(imm24), .Last(last), .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Instr(instr), .Addr(addr), .Err(err), .Done(done), .Clear(clear), .Count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy = 0;
  bit          m_last = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_addr = BASE;
  longint      m_next = BASE;
  longint      m_count = 0;

  function automatic logic [31:0] model_encode(longint c, longint o, longint f, longint r_n,
                                               longint r_d, longint s2, longint imm);
    longint w;
    if (o == 2) w = c * (64'd1 << 28) + o * (64'd1 << 26) + (f / 16) * (64'd1 << 24) + imm;
    else        w = c * (64'd1 << 28) + o * (64'd1 << 26) + f * (64'd1 << 20)
                    + r_n * (64'd1 << 16) + r_d * (64'd1 << 12) + s2;
    return w[31:0];
  endfunction

  function automatic bit model_illegal(longint o, longint f);
`ifdef INSTR_ENCODER_CHECK_EN
    longint mid;
    mid = (f / 2) % 16;
    if (o == 3 && mid > 8) return 1;
    if (o == 0 && (mid == 10 || mid == 11) && (f % 2) == 0) return 1;
    return 0;
`else
    return (o < 0) && (f < 0);
`endif
  endfunction

  function automatic bit model_in_ready();
    if (reset || m_done) return 0;
    if (m_busy) return out_ready && !m_last;
    return 1;
  endfunction

  task automatic model_step();
    bit acc, hs, ill, was_done, was_last;
    if (reset) begin
      m_busy = 0; m_last = 0; m_done = 0; m_err = 0;
      m_instr = '0; m_addr = BASE; m_next = BASE; m_count = 0;
      return;
    end
    acc      = in_valid && model_in_ready();
    hs       = m_busy && out_ready;
    ill      = model_illegal(longint'(op), longint'(funct));
    was_done = m_done;
    was_last = m_last;
    m_err    = acc && ill;
    if (hs) begin
      if (m_count < 65535) m_count++;
      m_busy = 0;
      if (was_last) m_done = 1;
    end
    if (was_done && clear) begin
      m_done = 0; m_addr = BASE; m_next = BASE; m_count = 0;
    end
    if (acc) begin
      if (ill) begin
        if (last) m_done = 1;
      end else begin
        m_busy  = 1;
        m_instr = model_encode(longint'(cond), longint'(op), longint'(funct), longint'(rn),
                               longint'(rd), longint'(src2), longint'(imm24));
        m_addr  = m_next[31:0];
        m_next  = (m_next + STEP) % (64'd1 << 32);
        m_last  = last;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      #2;
      check("in_ready", 32'(in_ready), 32'(model_in_ready()));
      check("out_valid", 32'(out_valid), 32'(m_busy));
      check("addr", addr, m_addr);
      check("count", 32'(count), m_count[31:0]);
      check("err", 32'(err), 32'(m_err));
      check("done", 32'(done), 32'(m_done));
      if (m_busy) check("instr", instr, m_instr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; clear = 0; last = 0;
    cond = '0; op = '0; funct = '0; rn = '0; rd = '0; src2 = '0; imm24 = '0;
  endtask

  task automatic set_req(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r_n, input logic [3:0] r_d, input logic [11:0] s2,
                         input logic [23:0] imm, input logic lst);
    in_valid = 1; cond = c; op = o; funct = f; rn = r_n; rd = r_d;
    src2 = s2; imm24 = imm; last = lst;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); reset = 1;
    #3 check("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk); reset = 0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_addr", addr, BASE);
    check("rst_count", 32'(count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready_high", 32'(in_ready), 32'd1);
  endtask

  initial begin
    @(posedge clk);
    cmp_on = 1;

    // Basic data-processing encode, latency 1.
    do_reset();
    @(negedge clk); set_req(4'hE, 2'b00, 6'b001000, 4'd1, 4'd2, 12'h005, 24'h0, 1'b0);
    out_ready = 1;
    @(negedge clk); in_valid = 0;
    #3;
    check("dp_instr", instr, 32'hE081_2005);
    check("dp_addr", addr, 32'hFFFF_FFF8);
    check("dp_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk); #3;
    check("dp_drained", 32'(out_valid), 32'd0);
    check("dp_count", 32'(count), 32'd1);

    // Three back-to-back words, address wrapping through zero.
    do_reset();
    @(negedge clk); set_req(4'h1, 2'b00, 6'h01, 4'd1, 4'd1, 12'h001, 24'h0, 1'b0); out_ready = 1;
    @(negedge clk); set_req(4'h2, 2'b01, 6'h02, 4'd2, 4'd2, 12'h002, 24'h0, 1'b0);
    #3 check("b2b_addr0", addr, 32'hFFFF_FFF8);
    @(negedge clk); set_req(4'h3, 2'b00, 6'h03, 4'd3, 4'd3, 12'h003, 24'h0, 1'b0);
    #3 check("b2b_addr1", addr, 32'hFFFF_FFFC);
    @(negedge clk); in_valid = 0;
    #3 check("b2b_addr2", addr, 32'h0000_0000);
    @(negedge clk); #3;
    check("b2b_count", 32'(count), 32'd3);
    check("b2b_idle", 32'(out_valid), 32'd0);

    // Backpressure: word held stable for five cycles.
    do_reset();
    @(negedge clk); set_req(4'h0, 2'b01, 6'b011001, 4'd3, 4'd4, 12'h123, 24'h0, 1'b0);
    out_ready = 0;
    @(negedge clk); set_req(4'h7, 2'b00, 6'h11, 4'd9, 4'd9, 12'hABC, 24'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #3;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_instr", instr, 32'h0593_4123);
      check("bp_addr", addr, 32'hFFFF_FFF8);
      @(negedge clk);
    end
    out_ready = 1; in_valid = 0;
    #3 check("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk); #3;
    check("bp_count", 32'(count), 32'd1);
    check("bp_idle", 32'(out_valid), 32'd0);

    // Branch with Last, DONE, then Clear.
    do_reset();
    @(negedge clk); set_req(4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 12'h0, 24'hFFFFFE, 1'b1);
    out_ready = 0;
    @(negedge clk); set_req(4'h1, 2'b00, 6'h01, 4'd1, 4'd1, 12'h1, 24'h0, 1'b0);
    out_ready = 1;
    #3;
    check("br_instr", instr, 32'hEAFF_FFFE);
    check("br_last_blocks", 32'(in_ready), 32'd0);
    @(negedge clk); #3;
    check("br_done", 32'(done), 32'd1);
    check("br_done_ready", 32'(in_ready), 32'd0);
    check("br_count", 32'(count), 32'd1);
    @(negedge clk); in_valid = 0; clear = 1;
    @(negedge clk); clear = 0;
    #3;
    check("clr_done", 32'(done), 32'd0);
    check("clr_addr", addr, BASE);
    check("clr_count", 32'(count), 32'd0);
    check("clr_ready", 32'(in_ready), 32'd1);

    // Multiply with out-of-range function.
    do_reset();
    @(negedge clk); set_req(4'hE, 2'b11, 6'b010010, 4'd5, 4'd6, 12'h0AB, 24'h0, 1'b0);
    out_ready = 0;
    @(negedge clk); in_valid = 0;
    #3;
`ifdef INSTR_ENCODER_CHECK_EN
    check("ill_err", 32'(err), 32'd1);
    check("ill_no_word", 32'(out_valid), 32'd0);
    check("ill_addr", addr, BASE);
    @(negedge clk); #3 check("ill_err_pulse", 32'(err), 32'd0);
`else
    check("mul_word", 32'(out_valid), 32'd1);
    check("mul_instr", instr, 32'hED25_60AB);
    check("mul_no_err", 32'(err), 32'd0);
`endif

    // Reset while a word is stalled.
    do_reset();
    @(negedge clk); set_req(4'h1, 2'b00, 6'h01, 4'd1, 4'd1, 12'h1, 24'h0, 1'b0); out_ready = 1;
    @(negedge clk); set_req(4'h2, 2'b00, 6'h02, 4'd2, 4'd2, 12'h2, 24'h0, 1'b0);
    @(negedge clk); in_valid = 0; out_ready = 0;
    #3 check("rmid_addr_before", addr, 32'hFFFF_FFFC);
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    #3;
    check("rmid_out_valid", 32'(out_valid), 32'd0);
    check("rmid_addr", addr, BASE);
    check("rmid_count", 32'(count), 32'd0);

    // Count saturation under sustained one-word-per-cycle traffic.
    do_reset();
    @(negedge clk); set_req(4'h5, 2'b00, 6'h04, 4'd7, 4'd8, 12'h055, 24'h0, 1'b0); out_ready = 1;
    repeat (65600) @(negedge clk);
    #3 check("count_saturated", 32'(count), 32'h0000_FFFF);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(299) == 0);
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      clear     = ($urandom_range(3) == 0);
      last      = ($urandom_range(15) == 0);
      cond      = 4'($urandom);
      op        = 2'($urandom);
      funct     = 6'($urandom);
      rn        = 4'($urandom);
      rd        = 4'($urandom);
      src2      = 12'($urandom);
      imm24     = 24'($urandom);
    end
    @(negedge clk); idle_inputs(); reset = 0;
    @(negedge clk);
    #4;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00000000: byte address of the first emitted instruction word.
REQ-002 Parameter ADDR_STEP, default 4: byte increment between consecutive emitted words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 In_Valid  input  1  request carries a valid instruction description.
REQ-006 In_Ready  output  1  encoder accepts the request this cycle.
REQ-007 Cond  input  4  condition field.
REQ-008 Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 multiply.
REQ-009 Funct  input  6  function field, same meaning as consumed by the decoder.
REQ-010 Rn, Rd  input  4 each  register fields.
REQ-011 Src2  input  12  operand-2 field (immediate or register/shift).
REQ-012 Imm24  input  24  branch offset, used only when Op=10.
REQ-013 Last  input  1  marks the final instruction of a program.
REQ-014 Out_Valid  output  1  Instr/Addr hold a word to be written to instruction memory.
REQ-015 Out_Ready  input  1  memory side accepts the word this cycle.
REQ-016 Instr  output  32  encoded instruction word.
REQ-017 Addr  output  32  byte address for Instr.
REQ-018 Err  output  1  one-cycle pulse: rejected illegal request.
REQ-019 Done  output  1  program complete; held until Clear.
REQ-020 Clear  input  1  leaves DONE, restarts address at BASE_ADDR.
REQ-021 Count  output  16  number of words accepted by memory side since reset/Clear.

Function
REQ-022 Encoding for Op≠10 SHALL be {Cond, Op, Funct, Rn, Rd, Src2}; for Op=10 {Cond, Op, Funct[5:4], Imm24}.
REQ-023 States SHALL be IDLE, OUT, DONE.
REQ-024 In_Ready SHALL be 1 in IDLE, equal Out_Ready in OUT, 0 in DONE.
REQ-025 Request accepted (In_Valid & In_Ready) at edge N SHALL present registered Instr/Addr with Out_Valid=1 from cycle N+1 (latency 1).
REQ-026 In OUT, Instr, Addr, Out_Valid SHALL hold stable until Out_Ready=1.
REQ-027 Out_Valid & Out_Ready with simultaneous accepted new request SHALL stay in OUT with the new word; sustained throughput one word per cycle.
REQ-028 Out_Valid & Out_Ready with no new request SHALL go to IDLE; Out_Valid=0.
REQ-029 Addr SHALL start at BASE_ADDR and advance by ADDR_STEP on each accepted request; 32-bit wrap-around without error.
REQ-030 Count SHALL increment on each Out_Valid & Out_Ready; saturates at 16'hFFFF.
REQ-031 Word accepted by memory side whose request had Last=1 SHALL go to DONE; Done=1 the following cycle; no new request accepted in that handshake cycle.
REQ-032 In DONE, Clear=1 SHALL go to IDLE, Done=0, Addr and Count return to BASE_ADDR and 0 next cycle; Clear outside DONE ignored.
REQ-033 Illegal request (when checked, see Configuration): Op=11 with Funct[4:1]>1000, or Op=00 with Funct[4:1] in {1010,1011} and Funct[0]=0.

Reset
REQ-034 reset SHALL force state IDLE, Out_Valid=0, Instr=0, Addr=BASE_ADDR, Count=0, Err=0, Done=0, In_Ready=0 during the reset cycle, 1 after.
REQ-035 reset mid-OUT SHALL discard the pending word without a memory handshake.
REQ-036 reset SHALL take priority over Clear, In_Valid and Out_Ready.

Configuration
REQ-037 Macro INSTR_ENCODER_CHECK_EN defined: illegal request SHALL be consumed (In_Ready as normal), not emitted, Addr not advanced, Err=1 one cycle after acceptance; Last on an illegal request still enters DONE once no word is pending.
REQ-038 Macro undefined: no checking, Err tied 0, every request encoded per REQ-022.

Verification
REQ-039 After reset, request Cond=1110 Op=00 Funct=001000 Rn=1 Rd=2 Src2=0x005, Out_Ready=1 -> next cycle Instr=0xE0812005, Addr=0x0, Out_Valid=1.
REQ-040 Three back-to-back requests, Out_Ready=1 -> Addr 0x0,0x4,0x8 on consecutive cycles, Count=3.
REQ-041 Out_Ready=0 for 5 cycles in OUT -> In_Ready=0, Instr/Addr unchanged; Out_Ready=1 -> word accepted, Count+1.
REQ-042 Branch Cond=1110 Op=10 Funct=10xxxx Imm24=0xFFFFFE, Last=1 -> Instr=0xEAFFFFFE, then Done=1, In_Ready=0; Clear -> IDLE, Addr=BASE_ADDR, Count=0.
REQ-043 With INSTR_ENCODER_CHECK_EN: Op=11 Funct=010010 -> Err pulse, Out_Valid stays 0, Addr unchanged; without macro -> word emitted.
REQ-044 reset asserted while Out_Valid=1 and Out_Ready=0 -> next cycle Out_Valid=0, Addr=BASE_ADDR, Count=0.
